// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Each grant is a burst of up to MAX_BURST beats, preceded by one arbitration cycle.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data
);

    localparam int unsigned OW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state;
    logic [BW-1:0]   beat_cnt;
    logic [OW-1:0]   pick;
    logic            found;
    int unsigned     idx;
    logic            own_req;
    logic            accept;
    logic            last_beat;

    // Next owner: first requester after the current owner, wrapping; owner itself is last.
    always_comb begin
        pick  = owner;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(owner) + k) % NUM_REQ;
            if (!found && req[OW'(idx)]) begin
                pick  = OW'(idx);
                found = 1'b1;
            end
        end
    end

    // Beat acceptance and write-port drive; state resets async so these clear at once.
    always_comb begin
        own_req      = req[owner];
        accept       = (state == BURST) && own_req && !fifo_full;
        last_beat    = (beat_cnt == BW'(MAX_BURST - 1));
        gnt          = '0;
        fifo_wr_en   = accept;
        fifo_wr_data = '0;
        if (accept) begin
            gnt[owner]   = 1'b1;
            fifo_wr_data = req_data[32'(owner)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Arbitration / burst FSM with registered owner pointer and busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= OW'(NUM_REQ - 1);
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner    <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                        busy     <= 1'b1;
                    end
                end
                BURST: begin
                    if (!own_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!fifo_full) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (last_beat) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
